// File: rtl/forward_wakeup_unit.sv
// forward_wakeup_unit
//
// Resolves the source operands of an issued instruction. Each source is
// taken from the register file, a bypass channel or the ROB. Sources that
// cannot be resolved when the request arrives are parked with their ROB tag.
// They are then woken up by snooping the bypass buses and the ROB on every
// cycle. Once every source is captured, the full operand set is presented to
// the consumer over a valid/ready handshake.
//
// Optional feature macro: FWD_STATS_EN adds saturating wait-cycle and
// request counters (stat_wait_cycles, stat_requests).
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   flush               synchronous pipeline flush, drops all held state
//   req_valid/ready     operand request handshake (stall = valid && !ready)
//   req_rf_data         register-file value per source
//   req_rob_entry       ROB tag per source
//   req_rob_entry_valid source still in flight, must come from bypass/ROB
//   rob_rd_entry        ROB read index per source
//   rob_rd_data/valid   ROB read data and completion flag, same cycle
//   byp_data/rob_id     bypass channel values and tags
//   byp_valid           bypass channel is live; channel 0 has top priority
//   out_valid/ready     resolved operand handshake
//   out_data            registered resolved operands, source i in slice i
//   stall               request present but not accepted

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module forward_wakeup_unit #(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int NUM_SRC         = 2,
  parameter int NUM_BYPASS      = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [NUM_SRC*WORD_SIZE-1:0]         req_rf_data,
  input  logic [NUM_SRC*ROB_ENTRY_WIDTH-1:0]   req_rob_entry,
  input  logic [NUM_SRC-1:0]                   req_rob_entry_valid,
  output logic [NUM_SRC*ROB_ENTRY_WIDTH-1:0]   rob_rd_entry,
  input  logic [NUM_SRC*WORD_SIZE-1:0]         rob_rd_data,
  input  logic [NUM_SRC-1:0]                   rob_rd_valid,
  input  logic [NUM_BYPASS*WORD_SIZE-1:0]      byp_data,
  input  logic [NUM_BYPASS*ROB_ENTRY_WIDTH-1:0] byp_rob_id,
  input  logic [NUM_BYPASS-1:0]                byp_valid,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_SRC*WORD_SIZE-1:0]         out_data,
  output logic                                 stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                          stat_wait_cycles,
  output logic [31:0]                          stat_requests
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t                       state_q;
  logic [NUM_SRC-1:0]           pend_q;
  logic [ROB_ENTRY_WIDTH-1:0]   tag_q   [NUM_SRC];
  logic [WORD_SIZE-1:0]         hold_q  [NUM_SRC];

  logic [NUM_SRC-1:0]           res_ok;
  logic [WORD_SIZE-1:0]         res_val [NUM_SRC];
  logic                         all_resolved;
  logic                         accept;

  // A request can only be taken when nothing is held, or when the held
  // result leaves this very cycle. Flush blocks acceptance outright.
  assign req_ready    = !flush && ((state_q == ST_IDLE) ||
                                   (state_q == ST_VALID && out_ready));
  assign accept       = req_valid && req_ready;
  assign stall        = req_valid && !req_ready;
  assign all_resolved = &res_ok;

  // Per-source resolution. Outside WAIT the incoming request is being
  // resolved; inside WAIT the latched pending bits and tags are. The bypass
  // scan runs from the highest index down so the lowest matching channel
  // overwrites the others and wins.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic                       in_flight;
    logic [ROB_ENTRY_WIDTH-1:0] cur_tag;
    logic                       src_ok;
    logic [WORD_SIZE-1:0]       src_val;

    assign in_flight = (state_q == ST_WAIT) ? pend_q[s] : req_rob_entry_valid[s];
    assign cur_tag   = (state_q == ST_WAIT) ? tag_q[s]
                                            : req_rob_entry[s*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
    assign rob_rd_entry[s*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] = cur_tag;

    always_comb begin
      src_ok  = 1'b0;
      src_val = '0;
      if (!in_flight) begin
        src_ok  = 1'b1;
        src_val = (state_q == ST_WAIT) ? hold_q[s] : req_rf_data[s*WORD_SIZE +: WORD_SIZE];
      end else begin
        for (int b = NUM_BYPASS - 1; b >= 0; b--) begin
          if (byp_valid[b] &&
              byp_rob_id[b*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] == cur_tag) begin
            src_ok  = 1'b1;
            src_val = byp_data[b*WORD_SIZE +: WORD_SIZE];
          end
        end
        if (!src_ok && rob_rd_valid[s]) begin
          src_ok  = 1'b1;
          src_val = rob_rd_data[s*WORD_SIZE +: WORD_SIZE];
        end
      end
    end

    assign res_ok[s]  = src_ok;
    assign res_val[s] = src_val;
  end

  // Main state machine. A request that resolves completely goes straight to
  // VALID; otherwise resolved values are parked in the holding registers and
  // the unresolved sources keep snooping in WAIT. Flush drops everything in
  // flight but leaves the data registers alone since they are qualified by
  // out_valid and the pending bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      pend_q    <= '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        tag_q[s]  <= '0;
        hold_q[s] <= '0;
      end
    end else if (flush) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      pend_q    <= '0;
    end else if (accept) begin
      if (all_resolved) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          out_data[s*WORD_SIZE +: WORD_SIZE] <= res_val[s];
        end
        state_q   <= ST_VALID;
        out_valid <= 1'b1;
      end else begin
        for (int s = 0; s < NUM_SRC; s++) begin
          hold_q[s] <= res_val[s];
          tag_q[s]  <= req_rob_entry[s*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
        end
        pend_q    <= ~res_ok;
        state_q   <= ST_WAIT;
        out_valid <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          for (int s = 0; s < NUM_SRC; s++) begin
            if (pend_q[s] && res_ok[s]) begin
              hold_q[s] <= res_val[s];
              pend_q[s] <= 1'b0;
            end
          end
          if (all_resolved) begin
            for (int s = 0; s < NUM_SRC; s++) begin
              out_data[s*WORD_SIZE +: WORD_SIZE] <= res_val[s];
            end
            state_q   <= ST_VALID;
            out_valid <= 1'b1;
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FWD_STATS_EN
  // Saturating statistics; only reset clears them so they survive flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wait_cycles <= '0;
      stat_requests    <= '0;
    end else begin
      if (state_q == ST_WAIT && stat_wait_cycles != 32'hFFFF_FFFF) begin
        stat_wait_cycles <= stat_wait_cycles + 32'd1;
      end
      if (accept && stat_requests != 32'hFFFF_FFFF) begin
        stat_requests <= stat_requests + 32'd1;
      end
    end
  end
`endif

endmodule
